// File: rtl/fp_add_pipe_if.sv
// Valid/ready operand and result bundle for the pipelined float adder.
// The producer/consumer side uses master; the adder uses slave.
interface fp_add_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         nan_flag;
  logic         overflow_flag;
  logic         underflow_flag;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, nan_flag, overflow_flag, underflow_flag
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, nan_flag, overflow_flag, underflow_flag
  );
endinterface

// File: rtl/fp_add_pipe.sv
// 3-stage pipelined IEEE-754 adder/subtractor: unpack/swap, align/add, normalise/round/pack.
// Denormal inputs and outputs are flushed to zero; all stages hold together under backpressure.
module fp_add_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic          clk,
  input logic          rst_n,
  fp_add_pipe_if.slave bus
);
  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned EXT_W = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int unsigned SUM_W = EXT_W + 1;
  localparam int unsigned EW2   = EXP_W + 2;
  localparam int unsigned LZ_W  = $clog2(EXT_W + 1);
  localparam logic [W-1:0]   QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EW2-1:0] EXP_ONES = EW2'((2**EXP_W) - 1);

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_x;
    logic [EXP_W-1:0] diff;
    logic             hid_x;
    logic             hid_y;
    logic [MAN_W-1:0] man_x;
    logic [MAN_W-1:0] man_y;
    logic             spec;
    logic             spec_nan;
    logic [W-1:0]     spec_val;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SUM_W-1:0] sum;
    logic             spec;
    logic             spec_nan;
    logic [W-1:0]     spec_val;
  } s2_t;

  function automatic logic [LZ_W-1:0] f_lzc(input logic [EXT_W-1:0] v);
    logic [LZ_W-1:0] n;
    logic            done;
    n    = '0;
    done = 1'b0;
    for (int i = EXT_W - 1; i >= 0; i--) begin
      if (!done) begin
        if (v[i]) done = 1'b1;
        else      n = n + LZ_W'(1);
      end
    end
    return n;
  endfunction

  s1_t r_s1, w_s1;
  s2_t r_s2, w_s2;
  logic         r_out_valid, r_nan, r_ovf, r_unf;
  logic [W-1:0] r_result;
  logic         w_stall;

  // Stage 1: classify, flush denormals, order so |X| >= |Y|.
  logic             w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_swap;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [W-2:0]     w_a_mag, w_b_mag, w_x_mag, w_y_mag;

  always_comb begin
    w_ea     = bus.a[W-2:MAN_W];
    w_eb     = bus.b[W-2:MAN_W];
    w_sa     = bus.a[W-1];
    w_sb     = bus.b[W-1] ^ bus.sub;
    w_a_zero = (w_ea == '0);
    w_b_zero = (w_eb == '0);
    w_a_inf  = (&w_ea) && (bus.a[MAN_W-1:0] == '0);
    w_b_inf  = (&w_eb) && (bus.b[MAN_W-1:0] == '0);
    w_a_nan  = (&w_ea) && (bus.a[MAN_W-1:0] != '0);
    w_b_nan  = (&w_eb) && (bus.b[MAN_W-1:0] != '0);
    w_a_mag  = w_a_zero ? '0 : bus.a[W-2:0];
    w_b_mag  = w_b_zero ? '0 : bus.b[W-2:0];
    w_swap   = (w_b_mag > w_a_mag);
    w_x_mag  = w_swap ? w_b_mag : w_a_mag;
    w_y_mag  = w_swap ? w_a_mag : w_b_mag;

    w_s1          = '0;
    w_s1.valid    = bus.in_valid;
    w_s1.sign     = w_swap ? w_sb : w_sa;
    w_s1.eff_sub  = w_sa ^ w_sb;
    w_s1.exp_x    = w_x_mag[W-2:MAN_W];
    w_s1.diff     = w_x_mag[W-2:MAN_W] - w_y_mag[W-2:MAN_W];
    w_s1.hid_x    = |w_x_mag[W-2:MAN_W];
    w_s1.hid_y    = |w_y_mag[W-2:MAN_W];
    w_s1.man_x    = w_x_mag[MAN_W-1:0];
    w_s1.man_y    = w_y_mag[MAN_W-1:0];
    w_s1.spec_nan = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb));
    w_s1.spec     = w_s1.spec_nan | w_a_inf | w_b_inf | (w_a_zero & w_b_zero);
    if (w_s1.spec_nan)  w_s1.spec_val = QNAN;
    else if (w_a_inf)   w_s1.spec_val = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (w_b_inf)   w_s1.spec_val = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                w_s1.spec_val = {w_sa & w_sb, {(W-1){1'b0}}};
  end

  // Stage 2: align Y with sticky collection, then add or subtract magnitudes.
  logic [EXT_W-1:0]   w_x_ext, w_y_ext, w_y_sh;
  logic [2*EXT_W-1:0] w_y_wide;

  always_comb begin
    w_x_ext  = {r_s1.hid_x, r_s1.man_x, 3'b000};
    w_y_ext  = {r_s1.hid_y, r_s1.man_y, 3'b000};
    w_y_wide = {w_y_ext, {EXT_W{1'b0}}} >> r_s1.diff;
    if (r_s1.diff >= EXP_W'(EXT_W - 1)) begin
      w_y_sh = {{(EXT_W-1){1'b0}}, |w_y_ext};
    end else begin
      w_y_sh = w_y_wide[2*EXT_W-1:EXT_W] | {{(EXT_W-1){1'b0}}, |w_y_wide[EXT_W-1:0]};
    end
    w_s2          = '0;
    w_s2.valid    = r_s1.valid;
    w_s2.sign     = r_s1.sign;
    w_s2.exp      = r_s1.exp_x;
    w_s2.sum      = r_s1.eff_sub ? ({1'b0, w_x_ext} - {1'b0, w_y_sh})
                                 : ({1'b0, w_x_ext} + {1'b0, w_y_sh});
    w_s2.spec     = r_s1.spec;
    w_s2.spec_nan = r_s1.spec_nan;
    w_s2.spec_val = r_s1.spec_val;
  end

  // Stage 3: normalise, round to nearest even, range check, pack.
  logic [LZ_W-1:0]  w_lz;
  logic [EXT_W-1:0] w_norm;
  logic [EW2-1:0]   w_exp_n, w_exp_f;
  logic [MAN_W+1:0] w_mant_r;
  logic [MAN_W-1:0] w_frac;
  logic             w_rnd, w_exp_low, w_exp_high;
  logic [W-1:0]     w_res;
  logic             w_nan, w_ovf, w_unf;

  always_comb begin
    w_lz = f_lzc(r_s2.sum[EXT_W-1:0]);
    if (r_s2.sum[SUM_W-1]) begin
      w_norm  = r_s2.sum[SUM_W-1:1] | {{(EXT_W-1){1'b0}}, r_s2.sum[0]};
      w_exp_n = {2'b00, r_s2.exp} + EW2'(1);
    end else begin
      w_norm  = r_s2.sum[EXT_W-1:0] << w_lz;
      w_exp_n = {2'b00, r_s2.exp} - EW2'(w_lz);
    end
    w_rnd      = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant_r   = {1'b0, w_norm[EXT_W-1:3]} + (MAN_W+2)'(w_rnd);
    w_frac     = w_mant_r[MAN_W+1] ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
    w_exp_f    = w_exp_n + EW2'(w_mant_r[MAN_W+1]);
    // Exponent arithmetic wraps negative into the top bit.
    w_exp_low  = w_exp_f[EW2-1] || (w_exp_f == '0);
    w_exp_high = !w_exp_f[EW2-1] && (w_exp_f >= EXP_ONES);

    w_res = {r_s2.sign, w_exp_f[EXP_W-1:0], w_frac};
    w_nan = 1'b0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (r_s2.spec) begin
      w_res = r_s2.spec_val;
      w_nan = r_s2.spec_nan;
    end else if (r_s2.sum == '0) begin
      w_res = '0;
    end else if (w_exp_high) begin
      w_res = {r_s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ovf = 1'b1;
    end else if (w_exp_low) begin
      w_res = {r_s2.sign, {(W-1){1'b0}}};
      w_unf = 1'b1;
    end
  end

  assign w_stall      = r_out_valid & ~bus.out_ready;
  assign bus.in_ready = ~w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_nan       <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else if (!w_stall) begin
      r_s1        <= w_s1;
      r_s2        <= w_s2;
      r_out_valid <= r_s2.valid;
      r_result    <= w_res;
      r_nan       <= w_nan;
      r_ovf       <= w_ovf;
      r_unf       <= w_unf;
    end
  end

  assign bus.out_valid      = r_out_valid;
  assign bus.result         = r_result;
  assign bus.nan_flag       = r_nan;
  assign bus.overflow_flag  = r_ovf;
  assign bus.underflow_flag = r_unf;
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed-vector bench for fp_add_pipe: specials, rounding, range, backpressure and reset flush.
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_add_pipe_if #(.EXP_W(8), .MAN_W(23)) u_if ();
  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [2:0]  flg;  // {nan, overflow, underflow}
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'b0, u_if.nan_flag, u_if.overflow_flag, u_if.underflow_flag};
  endfunction

  task automatic drive_vec(input int k);
    u_if.a   = vecs[k].a;
    u_if.b   = vecs[k].b;
    u_if.sub = vecs[k].sub;
  endtask

  task automatic run_op(input int k);
    @(negedge clk);
    u_if.in_valid  = 1'b1;
    u_if.out_ready = 1'b1;
    drive_vec(k);
    #1 check($sformatf("v%0d_in_ready", k), 32'(u_if.in_ready), 32'd1);
    @(posedge clk);
    #1 u_if.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check($sformatf("v%0d_early_valid", k), 32'(u_if.out_valid), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_valid", k), 32'(u_if.out_valid), 32'd1);
    check($sformatf("v%0d_result", k), u_if.result, vecs[k].res);
    check($sformatf("v%0d_flags", k), flags(), {29'b0, vecs[k].flg});
  endtask

  initial begin
    vecs[0]  = '{32'h7F800000, 32'h00000000, 1'b0, 32'h7F800000, 3'b000};
    vecs[1]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100};
    vecs[2]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100};
    vecs[3]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
    vecs[4]  = '{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 3'b000};
    vecs[5]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
    vecs[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000};
    vecs[7]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000};
    vecs[8]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010};
    vecs[9]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001};
    vecs[10] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
    vecs[11] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000};
    vecs[12] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000};
    vecs[13] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};
    vecs[14] = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000};
    vecs[15] = '{32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 3'b000};
    vecs[16] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000};
    vecs[17] = '{32'h3F800000, 32'hFFC00000, 1'b0, 32'h7FC00000, 3'b100};

    rst_n          = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    u_if.a         = '0;
    u_if.b         = '0;
    u_if.sub       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    check("rst_result", u_if.result, 32'd0);
    check("rst_flags", flags(), 32'd0);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 32'(u_if.in_ready), 32'd1);

    for (int k = 0; k < NV; k++) run_op(k);

    // Back-to-back stream of vectors 3..8 with a 4-cycle consumer stall.
    begin
      int          sent;
      int          got;
      logic        held;
      logic [31:0] prev;
      sent = 0;
      got  = 0;
      held = 1'b0;
      prev = '0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
        @(negedge clk);
        u_if.out_ready = !(cyc >= 4 && cyc < 8);
        u_if.in_valid  = (sent < 6);
        if (sent < 6) drive_vec(3 + sent);
        #1;
        if (u_if.out_valid && !u_if.out_ready) begin
          check($sformatf("stall_in_ready_c%0d", cyc), 32'(u_if.in_ready), 32'd0);
          if (held) check($sformatf("stall_stable_c%0d", cyc), u_if.result, prev);
          prev = u_if.result;
          held = 1'b1;
        end else begin
          held = 1'b0;
        end
        if (u_if.out_valid && u_if.out_ready) begin
          check($sformatf("stream_res%0d", got), u_if.result, vecs[3 + got].res);
          got++;
        end
        if (u_if.in_valid && u_if.in_ready) sent++;
      end
      check("stream_count", 32'(got), 32'd6);
      u_if.in_valid  = 1'b0;
      u_if.out_ready = 1'b1;
      @(negedge clk);
      check("stream_no_dup", 32'(u_if.out_valid), 32'd0);
    end

    // Three ops in flight, then asynchronous reset: nothing may emerge.
    begin
      int seen;
      seen = 0;
      @(negedge clk);
      u_if.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        u_if.in_valid = 1'b1;
        drive_vec(3 + i);
        @(negedge clk);
      end
      u_if.in_valid = 1'b0;
      check("flush_pre_valid", 32'(u_if.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("flush_out_valid", 32'(u_if.out_valid), 32'd0);
      check("flush_result", u_if.result, 32'd0);
      @(negedge clk);
      rst_n          = 1'b1;
      u_if.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (u_if.out_valid) seen++;
      end
      check("flush_none_emerge", 32'(seen), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
